ins_queue_reg: RTL and testbench

- Parametrised instruction register with a prefetch queue in front of it.
- Fetched instruction words are pushed into a DEPTH-entry FIFO through a valid/ready handshake.
- Pulsing loadIR pops one complete instruction into the output register and splits it into opcode and immediate/register fields.
- Opcodes at or above EXT_BASE are two-word instructions. Their second word is captured as an extended immediate.
- Sits between the fetch unit and the control FSM / decoder. The FSM uses out_valid in place of assuming the IR is always loaded.

---
 rtl/ins_queue_reg.sv | 155 +++++++++++++++
 tb/tb_ins_queue_reg.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ins_queue_reg.sv
`default_nettype none
// ============================================================================
// Module   : ins_queue_reg
// Purpose  : Instruction register fed by a DEPTH-entry prefetch FIFO.
//            Fetched words enter through a valid/ready handshake. A loadIR
//            pulse pops one complete instruction (one or two words) into the
//            IR and splits it into opcode / immediate fields. Opcodes at or
//            above EXT_BASE carry a second word captured as ext_imm.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            in_valid/in_ready   - fetch handshake
//            ins_in              - instruction word from fetch
//            loadIR              - load next complete instruction into IR
//            flush               - discard queue and invalidate IR
//            out_valid           - IR holds a valid instruction
//            opcode, imed_reg    - IR fields
//            has_ext, ext_imm    - two-word flag and extension word
//            count               - words currently queued
// Revision : 1.0 - initial release
// ============================================================================
module ins_queue_reg #(
  parameter int IW       = 8,
  parameter int OPW      = 4,
  parameter int DEPTH    = 4,
  parameter int EXT_BASE = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IW-1:0]                ins_in,
  input  logic                         loadIR,
  input  logic                         flush,
  output logic                         out_valid,
  output logic [OPW-1:0]               opcode,
  output logic [IW-OPW-1:0]            imed_reg,
  output logic                         has_ext,
  output logic [IW-1:0]                ext_imm,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  // One extra bit so EXT_BASE = 2^OPW (two-word disabled) is representable.
  localparam logic [OPW:0] c_ext_base = (OPW+1)'(EXT_BASE);

  logic [IW-1:0]      r_mem [DEPTH];
  logic [AW-1:0]      r_rd;
  logic [AW-1:0]      r_wr;
  logic [CW-1:0]      r_count;

  logic               r_out_valid;
  logic [OPW-1:0]     r_opcode;
  logic [IW-OPW-1:0]  r_imed;
  logic               r_has_ext;
  logic [IW-1:0]      r_ext_imm;

  logic [IW-1:0]      w_head;
  logic [IW-1:0]      w_second;
  logic [AW-1:0]      w_rd_p1;
  logic               w_head_two;
  logic               w_complete;
  logic               w_push;
  logic               w_pop1;
  logic               w_pop2;
  logic [CW-1:0]      w_count_nxt;
  logic [AW-1:0]      w_rd_nxt;

  assign in_ready  = (r_count < CW'(DEPTH));
  assign w_push    = in_valid && in_ready;

  // DEPTH is a power of two, so the AW-bit increment wraps modulo DEPTH.
  assign w_rd_p1   = r_rd + AW'(1);
  assign w_head    = r_mem[r_rd];
  assign w_second  = r_mem[w_rd_p1];

  assign w_head_two = ({1'b0, w_head[IW-1:IW-OPW]} >= c_ext_base);
  assign w_complete = w_head_two ? (r_count >= CW'(2)) : (r_count != '0);

  // flush overrides any load; an incomplete head never pops.
  assign w_pop1 = !flush && loadIR && w_complete && !w_head_two;
  assign w_pop2 = !flush && loadIR && w_complete &&  w_head_two;

  always_comb begin
    w_count_nxt = r_count;
    w_rd_nxt    = r_rd;
    if (w_pop1) begin
      w_rd_nxt    = w_rd_p1;
      w_count_nxt = r_count - CW'(1);
    end else if (w_pop2) begin
      w_rd_nxt    = r_rd + AW'(2);
      w_count_nxt = r_count - CW'(2);
    end
    if (w_push) begin
      w_count_nxt = w_count_nxt + CW'(1);
    end
  end

  // Storage needs no reset: only words behind valid pointers are ever read
  // into the IR.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[r_wr] <= ins_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      r_rd    <= w_rd_nxt;
      r_count <= w_count_nxt;
      if (w_push) begin
        r_wr <= r_wr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_opcode    <= '0;
      r_imed      <= '0;
      r_has_ext   <= 1'b0;
      r_ext_imm   <= '0;
    end else if (flush) begin
      // Fields are kept so a debugger still sees the last instruction.
      r_out_valid <= 1'b0;
    end else if (loadIR) begin
      if (w_complete) begin
        r_out_valid <= 1'b1;
        r_opcode    <= w_head[IW-1:IW-OPW];
        r_imed      <= w_head[IW-OPW-1:0];
        r_has_ext   <= w_head_two;
        r_ext_imm   <= w_head_two ? w_second : '0;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign opcode    = r_opcode;
  assign imed_reg  = r_imed;
  assign has_ext   = r_has_ext;
  assign ext_imm   = r_ext_imm;
  assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_ins_queue_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_ins_queue_reg
// Purpose  : Directed self-checking bench for ins_queue_reg with
//            hand-computed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ins_queue_reg;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] ins_in;
  logic       loadIR;
  logic       flush;
  logic       out_valid;
  logic [3:0] opcode;
  logic [3:0] imed_reg;
  logic       has_ext;
  logic [7:0] ext_imm;
  logic [2:0] count;

  int n_checks;
  int n_errors;

  ins_queue_reg #(.IW(8), .OPW(4), .DEPTH(4), .EXT_BASE(12)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ins_in   (ins_in),
    .loadIR   (loadIR),
    .flush    (flush),
    .out_valid(out_valid),
    .opcode   (opcode),
    .imed_reg (imed_reg),
    .has_ext  (has_ext),
    .ext_imm  (ext_imm),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge; outputs are sampled and inputs changed 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] w);
    in_valid = 1'b1;
    ins_in   = w;
    step();
    in_valid = 1'b0;
  endtask

  task automatic load();
    loadIR = 1'b1;
    step();
    loadIR = 1'b0;
  endtask

  task automatic check_ir(input string tag, input logic v, input logic [3:0] op,
                          input logic [3:0] im, input logic he, input logic [7:0] ex);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".op"},    32'(opcode),    32'(op));
    check({tag, ".imm"},   32'(imed_reg),  32'(im));
    check({tag, ".hext"},  32'(has_ext),   32'(he));
    check({tag, ".ext"},   32'(ext_imm),   32'(ex));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    ins_in   = '0;
    loadIR   = 1'b0;
    flush    = 1'b0;

    // Reset state
    repeat (2) step();
    check_ir("rst", 1'b0, 4'h0, 4'h0, 1'b0, 8'h00);
    check("rst.count", 32'(count), 0);
    check("rst.ready", 32'(in_ready), 1);
    rst_n = 1'b1;
    step();

    // One-word instruction
    push(8'h35);
    check("t1.count_a", 32'(count), 1);
    load();
    check_ir("t1", 1'b1, 4'h3, 4'h5, 1'b0, 8'h00);
    check("t1.count_b", 32'(count), 0);

    // Two-word instruction
    push(8'hC2);
    push(8'h7F);
    check("t2.count_a", 32'(count), 2);
    load();
    check_ir("t2", 1'b1, 4'hC, 4'h2, 1'b1, 8'h7F);
    check("t2.count_b", 32'(count), 0);

    // Incomplete head, then completion; pair straddles index 3 -> 0
    push(8'hC2);
    load();
    check_ir("t3a", 1'b0, 4'hC, 4'h2, 1'b1, 8'h7F);
    check("t3a.count", 32'(count), 1);
    push(8'h11);
    load();
    check_ir("t3b", 1'b1, 4'hC, 4'h2, 1'b1, 8'h11);
    check("t3b.count", 32'(count), 0);

    // Fill to full, overflow push ignored
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
    check("t4.count_full", 32'(count), 4);
    check("t4.ready_full", 32'(in_ready), 0);
    push(8'h99);
    check("t4.count_ovf", 32'(count), 4);
    for (int i = 0; i < 4; i++) begin
      load();
      check_ir($sformatf("t4.pop%0d", i), 1'b1, 4'h1, 4'(i), 1'b0, 8'h00);
      check($sformatf("t4.cnt%0d", i), 32'(count), 32'(3 - i));
    end
    check("t4.ready_empty", 32'(in_ready), 1);

    // Wrap: one-word 0x20, 0x21 at idx 1,2; pair D4/5A at idx 3,0
    push(8'h20);
    push(8'h21);
    push(8'hD4);
    push(8'h5A);
    load();
    check_ir("t5a", 1'b1, 4'h2, 4'h0, 1'b0, 8'h00);
    load();
    check_ir("t5b", 1'b1, 4'h2, 4'h1, 1'b0, 8'h00);
    load();
    check_ir("t5c", 1'b1, 4'hD, 4'h4, 1'b1, 8'h5A);
    check("t5.count", 32'(count), 0);

    // Opcode just below EXT_BASE is one-word
    push(8'hB7);
    load();
    check_ir("t6", 1'b1, 4'hB, 4'h7, 1'b0, 8'h00);

    // Simultaneous push and pop at count=1
    push(8'h42);
    in_valid = 1'b1;
    ins_in   = 8'h63;
    loadIR   = 1'b1;
    step();
    in_valid = 1'b0;
    loadIR   = 1'b0;
    check_ir("t7a", 1'b1, 4'h4, 4'h2, 1'b0, 8'h00);
    check("t7a.count", 32'(count), 1);
    load();
    check_ir("t7b", 1'b1, 4'h6, 4'h3, 1'b0, 8'h00);
    check("t7b.count", 32'(count), 0);

    // Flush with concurrent push and loadIR
    push(8'h71);
    push(8'h72);
    push(8'h73);
    check("t8.count_a", 32'(count), 3);
    flush    = 1'b1;
    in_valid = 1'b1;
    ins_in   = 8'h74;
    loadIR   = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    loadIR   = 1'b0;
    check_ir("t8", 1'b0, 4'h6, 4'h3, 1'b0, 8'h00);
    check("t8.count_b", 32'(count), 0);
    check("t8.ready", 32'(in_ready), 1);
    push(8'h85);
    load();
    check_ir("t8c", 1'b1, 4'h8, 4'h5, 1'b0, 8'h00);

    // Asynchronous reset between edges
    push(8'hC0);
    push(8'h91);
    check("t9.count_a", 32'(count), 2);
    check("t9.valid_a", 32'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_ir("t9", 1'b0, 4'h0, 4'h0, 1'b0, 8'h00);
    check("t9.count_b", 32'(count), 0);
    check("t9.ready", 32'(in_ready), 1);
    step();
    rst_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
